multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I main decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states instead of decoding in one cycle.
- Drives the shared-memory datapath, with a ready handshake on the unified instruction/data memory.
- Counts retired instructions and traps on unsupported opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)
ENABLE_IMM, 1, 1 = support I-format ALU (0010011); 0 = treat it as illegal

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  leave IDLE and begin fetching (sampled only in IDLE)
Op  input  7  IR[6:0] from instruction register; stable from DECODE through end of instruction
mem_ready  input  1  memory completes current read/write this cycle
IRWrite  output  1  load instruction register
PCWrite  output  1  unconditional PC update
PCWriteCond  output  1  PC update if ALU zero
PCSource  output  1  0 = ALU result, 1 = ALUOut (branch target)
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemtoReg  output  1  register writeback: 1 = MDR, 0 = ALUOut
RegWrite  output  1  register file write
ALUSrcA  output  1  0 = PC, 1 = rs1
ALUSrcB  output  2  00 = rs2, 01 = const 4, 10 = immediate
ALUOp  output  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
illegal_op  output  1  sticky trap flag
state  output  4  current state encoding, for debug
retired  output  CNT_W  retired-instruction count

Behaviour:
- State is registered; outputs are a Moore decode of state, except IRWrite/PCWrite in FETCH, which are gated by mem_ready.
- Unlisted outputs are 0 in every state; no X is ever driven.
- Reset (async, any cycle, mid-instruction included): state=IDLE, retired=0, illegal_op=0.
  - All outputs are 0 while reset is asserted and in IDLE.
  - An in-flight memory request is abandoned.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, EXEC_I=8, ALU_WB=9, BRANCH=10, TRAP=11.
- IDLE: start=1 -> FETCH, else stay.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - mem_ready=0: stay, outputs held.
  - mem_ready=1: IRWrite=1 and PCWrite=1 in that same cycle, -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (precomputes branch target). Next state by Op:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I if ENABLE_IMM=1, else TRAP
  - 1100011 -> BRANCH
  - any other value -> TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; Op=0000011 -> MEM_RD, else -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1; wait for mem_ready, then -> MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1; -> FETCH.
- MEM_WR: MemWrite=1, IorD=1; wait for mem_ready, then -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; -> ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11; -> ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0; -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1; -> FETCH.
- TRAP: illegal_op set on entry and held; stay until rst. No memory or register-file strobes.
- Cycle counts with zero memory wait:
  - load 5 (FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB)
  - store 4
  - R/I-type 4
  - branch 3
  - Each mem_ready=0 cycle adds one cycle.
- retired: +1 on every transition from MEM_WB, MEM_WR (with mem_ready), ALU_WB or BRANCH into FETCH.
  - Wraps from 2^CNT_W-1 to 0.
  - TRAP does not count.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- start outside IDLE is ignored.
- MemRead and MemWrite are never both 1.

Test Plan:
- Reset then start=1, mem_ready tied 1, R-type Op=0110011 -> states 1,2,7,9,1; RegWrite=1 only in ALU_WB; retired=1 after 4 cycles.
- Load Op=0000011, mem_ready low 3 cycles in MEM_RD -> MemRead/IorD held 4 cycles, then MEM_WB with MemtoReg=1, RegWrite=1; total 8 cycles; retired increments by 1.
- Store Op=0100011 then branch Op=1100011 -> MemWrite=1 only in MEM_WR; BRANCH asserts PCWriteCond=1, PCSource=1, ALUOp=01; retired=2 after 7 cycles.
- Op=1111111 in DECODE -> TRAP, illegal_op=1 held for 20 cycles, retired unchanged, all strobes 0.
- ENABLE_IMM=0 with Op=0010011 -> TRAP. ENABLE_IMM=1 with the same Op -> EXEC_I with ALUSrcB=10, ALUOp=11.
- Assert rst mid-MEM_RD with MemRead=1 -> all outputs 0 immediately (async), state=0, retired=0. Counter wrap: CNT_W=2, 4 R-type instructions -> retired back to 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a
// unified memory with a ready handshake, counts retired instructions and traps bad opcodes.
module multicycle_control_unit #(
    parameter int unsigned CNT_W      = 32,
    parameter bit          ENABLE_IMM = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       Op,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSource,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StExecR   = 4'd7,
        StExecI   = 4'd8,
        StAluWb   = 4'd9,
        StBranch  = 4'd10,
        StTrap    = 4'd11
    } stateT;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    stateT            stateQ, stateD;
    logic [CNT_W-1:0] retiredQ;
    logic             illegalQ;
    logic             retire;

    always_comb begin
        stateD = stateQ;
        retire = 1'b0;
        unique case (stateQ)
            StIdle:    if (start) stateD = StFetch;
            StFetch:   if (mem_ready) stateD = StDecode;
            StDecode: begin
                case (Op)
                    OpLoad, OpStore: stateD = StMemAddr;
                    OpRType:         stateD = StExecR;
                    OpIType:         stateD = ENABLE_IMM ? StExecI : StTrap;
                    OpBranch:        stateD = StBranch;
                    default:         stateD = StTrap;
                endcase
            end
            StMemAddr: stateD = (Op == OpLoad) ? StMemRd : StMemWr;
            StMemRd:   if (mem_ready) stateD = StMemWb;
            StMemWb: begin
                stateD = StFetch;
                retire = 1'b1;
            end
            StMemWr: begin
                if (mem_ready) begin
                    stateD = StFetch;
                    retire = 1'b1;
                end
            end
            StExecR,
            StExecI:   stateD = StAluWb;
            StAluWb,
            StBranch: begin
                stateD = StFetch;
                retire = 1'b1;
            end
            StTrap:    stateD = StTrap;
            default:   stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= StIdle;
            retiredQ <= '0;
            illegalQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (retire) retiredQ <= retiredQ + CntOne;
            // Flag rises together with the TRAP state so they are never seen apart.
            if (stateD == StTrap) illegalQ <= 1'b1;
        end
    end

    always_comb begin
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        unique case (stateQ)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR load and PC+4 commit only on the cycle memory delivers the word.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            StDecode:  ALUSrcB = 2'b10;
            StMemAddr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            StExecR: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            StExecI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            StAluWb:   RegWrite = 1'b1;
            StBranch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: ;
        endcase
    end

    assign state      = stateQ;
    assign retired    = retiredQ;
    assign illegal_op = illegalQ;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: vector table for the main instruction flow plus
// hand sequences for trap hold, ENABLE_IMM=0, async reset mid-access and counter wrap.
module tb_multicycle_control_unit;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpBad    = 7'b1111111;

    // {IRWrite,PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,MemtoReg,RegWrite,
    //  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0]}
    localparam logic [13:0] CtlZero    = 14'b00000000000000;
    localparam logic [13:0] CtlFetchW  = 14'b00000100000100;
    localparam logic [13:0] CtlFetchR  = 14'b11000100000100;
    localparam logic [13:0] CtlDecode  = 14'b00000000001000;
    localparam logic [13:0] CtlMemAddr = 14'b00000000011000;
    localparam logic [13:0] CtlMemRd   = 14'b00001100000000;
    localparam logic [13:0] CtlMemWb   = 14'b00000001100000;
    localparam logic [13:0] CtlMemWr   = 14'b00001010000000;
    localparam logic [13:0] CtlExecR   = 14'b00000000010010;
    localparam logic [13:0] CtlExecI   = 14'b00000000011011;
    localparam logic [13:0] CtlAluWb   = 14'b00000000100000;
    localparam logic [13:0] CtlBranch  = 14'b00110000010001;

    typedef struct {
        logic        start;
        logic [6:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [13:0] ctl;
        logic [31:0] ret;
        logic        ill;
    } vecT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [6:0] Op = 7'd0;
    logic mem_ready = 1'b0;

    logic IRWrite, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, MemtoReg, RegWrite;
    logic ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp;
    logic [3:0] state;
    logic [31:0] retired;

    logic nIRWrite, nPCWrite, nPCWriteCond, nPCSource, nIorD, nMemRead, nMemWrite, nMemtoReg;
    logic nRegWrite, nALUSrcA, nIllegal;
    logic [1:0] nALUSrcB, nALUOp;
    logic [3:0] nState;
    logic [31:0] nRetired;

    logic sIRWrite, sPCWrite, sPCWriteCond, sPCSource, sIorD, sMemRead, sMemWrite, sMemtoReg;
    logic sRegWrite, sALUSrcA, sIllegal;
    logic [1:0] sALUSrcB, sALUOp;
    logic [3:0] sState;
    logic [1:0] sRetired;

    logic [13:0] ctl;
    assign ctl = {IRWrite, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, MemtoReg,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp};

    int nCmp = 0;
    int nBad = 0;
    vecT vecs[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.CNT_W(32), .ENABLE_IMM(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .Op(Op), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .illegal_op(illegal_op), .state(state), .retired(retired)
    );

    multicycle_control_unit #(.CNT_W(32), .ENABLE_IMM(1'b0)) dutNoImm (
        .clk(clk), .rst(rst), .start(start), .Op(Op), .mem_ready(mem_ready),
        .IRWrite(nIRWrite), .PCWrite(nPCWrite), .PCWriteCond(nPCWriteCond),
        .PCSource(nPCSource), .IorD(nIorD), .MemRead(nMemRead), .MemWrite(nMemWrite),
        .MemtoReg(nMemtoReg), .RegWrite(nRegWrite), .ALUSrcA(nALUSrcA), .ALUSrcB(nALUSrcB),
        .ALUOp(nALUOp), .illegal_op(nIllegal), .state(nState), .retired(nRetired)
    );

    multicycle_control_unit #(.CNT_W(2), .ENABLE_IMM(1'b1)) dutSmall (
        .clk(clk), .rst(rst), .start(start), .Op(Op), .mem_ready(mem_ready),
        .IRWrite(sIRWrite), .PCWrite(sPCWrite), .PCWriteCond(sPCWriteCond),
        .PCSource(sPCSource), .IorD(sIorD), .MemRead(sMemRead), .MemWrite(sMemWrite),
        .MemtoReg(sMemtoReg), .RegWrite(sRegWrite), .ALUSrcA(sALUSrcA), .ALUSrcB(sALUSrcB),
        .ALUOp(sALUOp), .illegal_op(sIllegal), .state(sState), .retired(sRetired)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic [6:0] o, input logic r, input logic [3:0] st,
                       input logic [13:0] c, input logic [31:0] ret, input logic ill);
        vecs.push_back('{s, o, r, st, c, ret, ill});
    endtask

    initial begin
        // IDLE, start pulse, then R-type
        add(0, OpR, 1, 0, CtlZero, 0, 0);
        add(1, OpR, 1, 0, CtlZero, 0, 0);
        add(0, OpR, 1, 1, CtlFetchR, 0, 0);
        add(0, OpR, 1, 2, CtlDecode, 0, 0);
        add(0, OpR, 1, 7, CtlExecR, 0, 0);
        add(0, OpR, 1, 9, CtlAluWb, 0, 0);
        // load with three wait cycles in MEM_RD
        add(0, OpLoad, 1, 1, CtlFetchR, 1, 0);
        add(0, OpLoad, 1, 2, CtlDecode, 1, 0);
        add(0, OpLoad, 1, 3, CtlMemAddr, 1, 0);
        add(0, OpLoad, 0, 4, CtlMemRd, 1, 0);
        add(0, OpLoad, 0, 4, CtlMemRd, 1, 0);
        add(0, OpLoad, 0, 4, CtlMemRd, 1, 0);
        add(0, OpLoad, 1, 4, CtlMemRd, 1, 0);
        add(0, OpLoad, 1, 5, CtlMemWb, 1, 0);
        // store, then branch
        add(0, OpStore, 1, 1, CtlFetchR, 2, 0);
        add(0, OpStore, 1, 2, CtlDecode, 2, 0);
        add(0, OpStore, 1, 3, CtlMemAddr, 2, 0);
        add(0, OpStore, 1, 6, CtlMemWr, 2, 0);
        add(0, OpBranch, 1, 1, CtlFetchR, 3, 0);
        add(0, OpBranch, 1, 2, CtlDecode, 3, 0);
        add(0, OpBranch, 1, 10, CtlBranch, 3, 0);
        // I-type (counter of the 2-bit instance wraps 3 -> 0 here)
        add(0, OpI, 1, 1, CtlFetchR, 4, 0);
        add(0, OpI, 1, 2, CtlDecode, 4, 0);
        add(0, OpI, 1, 8, CtlExecI, 4, 0);
        add(0, OpI, 1, 9, CtlAluWb, 4, 0);
        // fetch wait; start and mem_ready must be ignored where irrelevant
        add(1, OpR, 0, 1, CtlFetchW, 5, 0);
        add(1, OpR, 1, 1, CtlFetchR, 5, 0);
        add(0, OpR, 0, 2, CtlDecode, 5, 0);
        add(0, OpR, 0, 7, CtlExecR, 5, 0);
        add(0, OpR, 0, 9, CtlAluWb, 5, 0);
        // illegal opcode
        add(0, OpBad, 1, 1, CtlFetchR, 6, 0);
        add(0, OpBad, 1, 2, CtlDecode, 6, 0);
        add(0, OpBad, 1, 11, CtlZero, 6, 1);

        #1 rst = 1'b1;
        start = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_state", 0, 32'(state), 32'd0);
        check("rst_ctl", 0, 32'(ctl), 32'(CtlZero));
        nextCycle();
        check("rst_hold_state", 0, 32'(state), 32'd0);
        check("rst_retired", 0, retired, 32'd0);
        check("rst_illegal", 0, 32'(illegal_op), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            start = vecs[i].start;
            Op = vecs[i].op;
            mem_ready = vecs[i].rdy;
            #1;
            check("vec_state", i, 32'(state), 32'(vecs[i].st));
            check("vec_ctl", i, 32'(ctl), 32'(vecs[i].ctl));
            check("vec_retired", i, retired, vecs[i].ret);
            check("vec_illegal", i, 32'(illegal_op), 32'(vecs[i].ill));
            check("vec_retired_w2", i, 32'(sRetired), vecs[i].ret % 4);
            nextCycle();
        end

        // TRAP holds regardless of start/mem_ready
        for (int i = 0; i < 20; i++) begin
            start = 1'b1;
            mem_ready = i[0];
            #1;
            check("trap_state", i, 32'(state), 32'd11);
            check("trap_ctl", i, 32'(ctl), 32'(CtlZero));
            check("trap_illegal", i, 32'(illegal_op), 32'd1);
            check("trap_retired", i, retired, 32'd6);
            nextCycle();
        end

        // I-type with and without ENABLE_IMM
        rst = 1'b1;
        #1 rst = 1'b0;
        start = 1'b1;
        Op = OpI;
        mem_ready = 1'b1;
        nextCycle();
        start = 1'b0;
        nextCycle();
        nextCycle();
        check("imm_on_state", 0, 32'(state), 32'd8);
        check("imm_on_ctl", 0, 32'(ctl), 32'(CtlExecI));
        check("imm_off_state", 0, 32'(nState), 32'd11);
        check("imm_off_illegal", 0, 32'(nIllegal), 32'd1);
        check("imm_off_retired", 0, nRetired, 32'd0);
        nextCycle();
        nextCycle();
        check("imm_retired", 0, retired, 32'd1);

        // async reset in the middle of a stalled load read
        Op = OpLoad;
        nextCycle();
        nextCycle();
        mem_ready = 1'b0;
        nextCycle();
        check("mid_rd_state", 0, 32'(state), 32'd4);
        check("mid_rd_memread", 0, 32'(MemRead), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_state", 0, 32'(state), 32'd0);
        check("async_ctl", 0, 32'(ctl), 32'(CtlZero));
        check("async_retired", 0, retired, 32'd0);
        check("async_illegal_noimm", 0, 32'(nIllegal), 32'd0);
        #1 rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
